// File: rtl/ex_mem_stage_pkg.sv
// ----------------------------------------------------------------------------
// ex_mem_stage_pkg
//   Shared widths, cause codes and helper types for the EX/MEM pipeline
//   register of the 5-stage MIPS core.
//   DW      : datapath width (ALU result, store data, PC)
//   RW      : register-specifier width
//   CW      : exception cause width
//   EXC_OV  : cause code written on arithmetic overflow
// ----------------------------------------------------------------------------
package ex_mem_stage_pkg;

   localparam int DW = 32;
   localparam int RW = 5;
   localparam int CW = 5;

   localparam logic [CW-1:0] EXC_OV = 5'd12;

   // Control bits carried alongside the data through EX/MEM.
   typedef struct packed {
      logic valid;
      logic reg_write;
      logic mem_read;
      logic mem_write;
      logic mem_to_reg;
   } mem_ctrl_t;

   localparam mem_ctrl_t CTRL_BUBBLE = mem_ctrl_t'(5'b00000);

   // An overflow only traps for a real instruction that asked for trapping.
   function automatic logic ovf_trap(input logic valid, input logic ovf_en,
                                     input logic overflow);
      return valid & ovf_en & overflow;
   endfunction

endpackage

// File: rtl/ex_mem_stage_if.sv
// ----------------------------------------------------------------------------
// ex_mem_stage_if
//   Bundle between the EX stage / hazard unit (master) and the EX/MEM
//   pipeline register (slave).
//   master drives : ex_* instruction fields, stall, flush, exc_clr
//   slave drives  : mem_* registered fields, fwd_en, load_pending,
//                   exc_req, exc_pending, epc, exc_cause
// ----------------------------------------------------------------------------
interface ex_mem_stage_if;
   import ex_mem_stage_pkg::*;

   logic          ex_valid;
   logic [DW-1:0] ex_pc;
   logic [DW-1:0] ex_alu_result;
   logic          ex_overflow;
   logic          ex_ovf_en;
   logic          ex_reg_write;
   logic          ex_mem_read;
   logic          ex_mem_write;
   logic          ex_mem_to_reg;
   logic [RW-1:0] ex_write_reg;
   logic [DW-1:0] ex_store_data;
   logic          stall;
   logic          flush;
   logic          exc_clr;

   logic          mem_valid;
   logic          mem_reg_write;
   logic          mem_mem_read;
   logic          mem_mem_write;
   logic          mem_mem_to_reg;
   logic [DW-1:0] mem_alu_result;
   logic [DW-1:0] mem_store_data;
   logic [RW-1:0] mem_write_reg;
   logic          fwd_en;
   logic          load_pending;
   logic          exc_req;
   logic          exc_pending;
   logic [DW-1:0] epc;
   logic [CW-1:0] exc_cause;

   modport master (
      output ex_valid, ex_pc, ex_alu_result, ex_overflow, ex_ovf_en,
             ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
             ex_write_reg, ex_store_data, stall, flush, exc_clr,
      input  mem_valid, mem_reg_write, mem_mem_read, mem_mem_write,
             mem_mem_to_reg, mem_alu_result, mem_store_data, mem_write_reg,
             fwd_en, load_pending, exc_req, exc_pending, epc, exc_cause
   );

   modport slave (
      input  ex_valid, ex_pc, ex_alu_result, ex_overflow, ex_ovf_en,
             ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
             ex_write_reg, ex_store_data, stall, flush, exc_clr,
      output mem_valid, mem_reg_write, mem_mem_read, mem_mem_write,
             mem_mem_to_reg, mem_alu_result, mem_store_data, mem_write_reg,
             fwd_en, load_pending, exc_req, exc_pending, epc, exc_cause
   );

endinterface

// File: rtl/ex_mem_stage_exc_capture.sv
// ----------------------------------------------------------------------------
// ex_mem_exc_capture
//   Records a precise arithmetic-overflow trap: one-cycle request, sticky
//   pending flag, faulting PC and cause code.
//   clk, rst_n     : clock, asynchronous active-low reset
//   advance_i      : EX/MEM is loading this edge (no flush, no stall)
//   trap_i         : qualified overflow of the EX instruction
//   pc_i           : PC of the EX instruction
//   exc_clr_i      : handler done, drop the pending flag
//   exc_req_o      : one-cycle trap request
//   exc_pending_o  : trap taken and not yet cleared
//   epc_o          : PC of the faulting instruction
//   exc_cause_o    : cause code
// ----------------------------------------------------------------------------
module ex_mem_exc_capture
   import ex_mem_stage_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          advance_i,
   input  logic          trap_i,
   input  logic [DW-1:0] pc_i,
   input  logic          exc_clr_i,
   output logic          exc_req_o,
   output logic          exc_pending_o,
   output logic [DW-1:0] epc_o,
   output logic [CW-1:0] exc_cause_o
);

   logic          req_q,     req_d;
   logic          pending_q, pending_d;
   logic [DW-1:0] epc_q,     epc_d;
   logic [CW-1:0] cause_q,   cause_d;
   logic          take_s;

   // A clear arriving with a new trap frees the slot, so the new trap is
   // recorded; a trap while still pending only has its side effects killed.
   assign take_s = advance_i & trap_i & (~pending_q | exc_clr_i);

   // Next-state selection for the trap record.
   always_comb begin
      req_d     = 1'b0;
      pending_d = pending_q;
      epc_d     = epc_q;
      cause_d   = cause_q;
      if (take_s) begin
         req_d     = 1'b1;
         pending_d = 1'b1;
         epc_d     = pc_i;
         cause_d   = EXC_OV;
      end else if (exc_clr_i) begin
         pending_d = 1'b0;
      end else begin
         pending_d = pending_q;
      end
   end

   // Trap record registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_q     <= 1'b0;
         pending_q <= 1'b0;
         epc_q     <= {DW{1'b0}};
         cause_q   <= {CW{1'b0}};
      end else begin
         req_q     <= req_d;
         pending_q <= pending_d;
         epc_q     <= epc_d;
         cause_q   <= cause_d;
      end
   end

   assign exc_req_o     = req_q;
   assign exc_pending_o = pending_q;
   assign epc_o         = epc_q;
   assign exc_cause_o   = cause_q;

endmodule

// File: rtl/ex_mem_stage.sv
// ----------------------------------------------------------------------------
// ex_mem_stage
//   EX/MEM pipeline register. Captures ALU result, store data, destination
//   and control each edge, applies flush (bubble) and stall (hold), kills
//   side effects of overflowing instructions and hands trap recording to
//   ex_mem_exc_capture.
//   clk   : core clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : ex_mem_stage_if.slave (EX inputs, pipeline control, MEM outputs)
// ----------------------------------------------------------------------------
module ex_mem_stage
   import ex_mem_stage_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   ex_mem_stage_if.slave        bus
);

   mem_ctrl_t     ctrl_q,   ctrl_d;
   logic [DW-1:0] alu_q,    alu_d;
   logic [DW-1:0] sdata_q,  sdata_d;
   logic [RW-1:0] wreg_q,   wreg_d;
   logic          advance_s;
   logic          trap_s;

   assign advance_s = ~bus.flush & ~bus.stall;
   assign trap_s    = ovf_trap(bus.ex_valid, bus.ex_ovf_en, bus.ex_overflow);

   // Pipeline register next state: flush > stall > load.
   always_comb begin
      ctrl_d  = ctrl_q;
      alu_d   = alu_q;
      sdata_d = sdata_q;
      wreg_d  = wreg_q;
      if (bus.flush) begin
         ctrl_d = CTRL_BUBBLE;
      end else if (bus.stall) begin
         ctrl_d = ctrl_q;
      end else begin
         ctrl_d.valid      = bus.ex_valid;
         // Writes to $0 are dropped; a trapping instruction keeps its slot
         // (valid) but loses every architectural side effect.
         ctrl_d.reg_write  = bus.ex_valid & bus.ex_reg_write & ~trap_s &
                             (bus.ex_write_reg != {RW{1'b0}});
         ctrl_d.mem_read   = bus.ex_valid & bus.ex_mem_read  & ~trap_s;
         ctrl_d.mem_write  = bus.ex_valid & bus.ex_mem_write & ~trap_s;
         ctrl_d.mem_to_reg = bus.ex_valid & bus.ex_mem_to_reg;
         alu_d             = bus.ex_alu_result;
         sdata_d           = bus.ex_store_data;
         wreg_d            = bus.ex_write_reg;
      end
   end

   // Pipeline register state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_q  <= CTRL_BUBBLE;
         alu_q   <= {DW{1'b0}};
         sdata_q <= {DW{1'b0}};
         wreg_q  <= {RW{1'b0}};
      end else begin
         ctrl_q  <= ctrl_d;
         alu_q   <= alu_d;
         sdata_q <= sdata_d;
         wreg_q  <= wreg_d;
      end
   end

   ex_mem_exc_capture u_exc (
      .clk           (clk),
      .rst_n         (rst_n),
      .advance_i     (advance_s),
      .trap_i        (trap_s),
      .pc_i          (bus.ex_pc),
      .exc_clr_i     (bus.exc_clr),
      .exc_req_o     (bus.exc_req),
      .exc_pending_o (bus.exc_pending),
      .epc_o         (bus.epc),
      .exc_cause_o   (bus.exc_cause)
   );

   assign bus.mem_valid      = ctrl_q.valid;
   assign bus.mem_reg_write  = ctrl_q.reg_write;
   assign bus.mem_mem_read   = ctrl_q.mem_read;
   assign bus.mem_mem_write  = ctrl_q.mem_write;
   assign bus.mem_mem_to_reg = ctrl_q.mem_to_reg;
   assign bus.mem_alu_result = alu_q;
   assign bus.mem_store_data = sdata_q;
   assign bus.mem_write_reg  = wreg_q;

   // Only ALU results are forwardable from MEM; load data is not ready yet.
   assign bus.fwd_en       = ctrl_q.valid & ctrl_q.reg_write & ~ctrl_q.mem_to_reg;
   assign bus.load_pending = ctrl_q.valid & ctrl_q.mem_read;

endmodule

// File: tb/tb_ex_mem_stage.sv
// ----------------------------------------------------------------------------
// tb_ex_mem_stage
//   Directed scenarios followed by randomized traffic, every output compared
//   against a behavioural model of the EX/MEM register rules.
// ----------------------------------------------------------------------------
module tb_ex_mem_stage;
   import ex_mem_stage_pkg::*;

   logic clk;
   logic rst_n;

   ex_mem_stage_if bus ();

   ex_mem_stage dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks;
   int n_fails;

   // model state
   logic          m_valid, m_rw, m_mr, m_mw, m_m2r;
   logic [31:0]   m_alu, m_sd, m_epc;
   logic [4:0]    m_wr, m_cause;
   logic          m_req, m_pend;

   task automatic check_eq(input string tag, input logic [63:0] obs,
                           input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_valid = 1'b0; m_rw = 1'b0; m_mr = 1'b0; m_mw = 1'b0; m_m2r = 1'b0;
      m_alu = 32'd0; m_sd = 32'd0; m_epc = 32'd0;
      m_wr = 5'd0; m_cause = 5'd0; m_req = 1'b0; m_pend = 1'b0;
   endtask

   // Apply the stage rules to the inputs currently on the bus.
   task automatic model_edge();
      bit loads, overflowed, slot_free, new_trap;
      loads      = !bus.flush && !bus.stall;
      overflowed = bus.ex_valid && bus.ex_ovf_en && bus.ex_overflow;
      slot_free  = !m_pend || bus.exc_clr;
      new_trap   = loads && overflowed && slot_free;
      if (bus.flush) begin
         {m_valid, m_rw, m_mr, m_mw, m_m2r} = 5'b00000;
      end else if (loads) begin
         m_valid = bus.ex_valid;
         m_rw    = bus.ex_valid && bus.ex_reg_write && !overflowed && bus.ex_write_reg != 5'd0;
         m_mr    = bus.ex_valid && bus.ex_mem_read && !overflowed;
         m_mw    = bus.ex_valid && bus.ex_mem_write && !overflowed;
         m_m2r   = bus.ex_valid && bus.ex_mem_to_reg;
         m_alu   = bus.ex_alu_result;
         m_sd    = bus.ex_store_data;
         m_wr    = bus.ex_write_reg;
      end
      m_req = new_trap;
      if (new_trap) begin
         m_pend  = 1'b1;
         m_epc   = bus.ex_pc;
         m_cause = 5'd12;
      end else if (bus.exc_clr) begin
         m_pend = 1'b0;
      end
   endtask

   task automatic compare_all(input string tag);
      check_eq({tag, ".valid"}, bus.mem_valid, m_valid);
      check_eq({tag, ".rw"},    bus.mem_reg_write, m_rw);
      check_eq({tag, ".mr"},    bus.mem_mem_read, m_mr);
      check_eq({tag, ".mw"},    bus.mem_mem_write, m_mw);
      check_eq({tag, ".m2r"},   bus.mem_mem_to_reg, m_m2r);
      check_eq({tag, ".alu"},   bus.mem_alu_result, m_alu);
      check_eq({tag, ".sd"},    bus.mem_store_data, m_sd);
      check_eq({tag, ".wr"},    bus.mem_write_reg, m_wr);
      check_eq({tag, ".fwd"},   bus.fwd_en, m_valid & m_rw & ~m_m2r);
      check_eq({tag, ".ldp"},   bus.load_pending, m_valid & m_mr);
      check_eq({tag, ".req"},   bus.exc_req, m_req);
      check_eq({tag, ".pend"},  bus.exc_pending, m_pend);
      check_eq({tag, ".epc"},   bus.epc, m_epc);
      check_eq({tag, ".cause"}, bus.exc_cause, m_cause);
   endtask

   // One clock: update model from present inputs, clock, sample #1 after.
   task automatic step(input string tag);
      model_edge();
      @(posedge clk);
      #1;
      compare_all(tag);
   endtask

   task automatic idle_inputs();
      bus.ex_valid = 1'b0; bus.ex_pc = 32'd0; bus.ex_alu_result = 32'd0;
      bus.ex_overflow = 1'b0; bus.ex_ovf_en = 1'b0; bus.ex_reg_write = 1'b0;
      bus.ex_mem_read = 1'b0; bus.ex_mem_write = 1'b0; bus.ex_mem_to_reg = 1'b0;
      bus.ex_write_reg = 5'd0; bus.ex_store_data = 32'd0;
      bus.stall = 1'b0; bus.flush = 1'b0; bus.exc_clr = 1'b0;
   endtask

   task automatic rand_inputs();
      bus.ex_valid      = ($urandom_range(0, 4) != 0);
      bus.ex_pc         = {$urandom_range(0, 32'h3fff_ffff), 2'b00};
      bus.ex_alu_result = $urandom;
      bus.ex_overflow   = ($urandom_range(0, 2) == 0);
      bus.ex_ovf_en     = $urandom_range(0, 1);
      bus.ex_reg_write  = $urandom_range(0, 1);
      bus.ex_mem_read   = $urandom_range(0, 1);
      bus.ex_mem_write  = $urandom_range(0, 1);
      bus.ex_mem_to_reg = $urandom_range(0, 1);
      bus.ex_write_reg  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      bus.ex_store_data = $urandom;
      bus.stall         = ($urandom_range(0, 5) == 0);
      bus.flush         = ($urandom_range(0, 7) == 0);
      bus.exc_clr       = ($urandom_range(0, 9) == 0);
   endtask

   initial begin
      logic [31:0] frozen_alu;
      logic [4:0]  frozen_wr;
      n_checks = 0;
      n_fails  = 0;
      idle_inputs();
      model_reset();
      rst_n = 1'b0;
      #12;
      compare_all("reset0");
      @(negedge clk);
      rst_n = 1'b1;

      // Reset: load some state, then assert reset mid-cycle.
      rand_inputs();
      bus.stall = 1'b0; bus.flush = 1'b0;
      bus.ex_valid = 1'b1; bus.ex_ovf_en = 1'b1; bus.ex_overflow = 1'b1;
      step("preload");
      #3;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_eq("rst.valid", bus.mem_valid, 1'b0);
      check_eq("rst.alu",   bus.mem_alu_result, 32'd0);
      check_eq("rst.pend",  bus.exc_pending, 1'b0);
      check_eq("rst.epc",   bus.epc, 32'd0);
      compare_all("rst");
      @(negedge clk);
      rst_n = 1'b1;
      idle_inputs();

      // Plain load and $0 rule.
      bus.ex_valid = 1'b1; bus.ex_alu_result = 32'h0000_1234;
      bus.ex_reg_write = 1'b1; bus.ex_write_reg = 5'd8;
      step("load");
      check_eq("load.alu", bus.mem_alu_result, 32'h0000_1234);
      check_eq("load.rw",  bus.mem_reg_write, 1'b1);
      check_eq("load.fwd", bus.fwd_en, 1'b1);
      bus.ex_write_reg = 5'd0;
      step("zero");
      check_eq("zero.rw", bus.mem_reg_write, 1'b0);

      // Overflow trap.
      bus.ex_pc = 32'h0040_0010; bus.ex_ovf_en = 1'b1; bus.ex_overflow = 1'b1;
      bus.ex_write_reg = 5'd8;
      step("ovf");
      check_eq("ovf.req",   bus.exc_req, 1'b1);
      check_eq("ovf.epc",   bus.epc, 32'h0040_0010);
      check_eq("ovf.cause", bus.exc_cause, 32'd12);
      check_eq("ovf.rw",    bus.mem_reg_write, 1'b0);
      // Back-to-back overflow while pending.
      bus.ex_pc = 32'h0040_0014;
      step("ovf2");
      check_eq("ovf2.req", bus.exc_req, 1'b0);
      check_eq("ovf2.epc", bus.epc, 32'h0040_0010);
      // Overflow without trap enable.
      bus.ex_ovf_en = 1'b0; bus.ex_pc = 32'h0040_0020;
      step("noen");
      check_eq("noen.req", bus.exc_req, 1'b0);
      check_eq("noen.rw",  bus.mem_reg_write, 1'b1);
      // exc_clr together with a new overflow.
      bus.ex_ovf_en = 1'b1; bus.ex_pc = 32'h0040_0018; bus.exc_clr = 1'b1;
      step("clrovf");
      check_eq("clrovf.epc",  bus.epc, 32'h0040_0018);
      check_eq("clrovf.req",  bus.exc_req, 1'b1);
      check_eq("clrovf.pend", bus.exc_pending, 1'b1);
      bus.exc_clr = 1'b0; bus.ex_overflow = 1'b0;
      step("idle1");

      // Stall with changing inputs.
      frozen_alu = bus.mem_alu_result;
      frozen_wr  = bus.mem_write_reg;
      bus.stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.ex_alu_result = 32'hA5A5_0000 + 32'(i);
         bus.ex_write_reg  = 5'(i + 20);
         step("stall");
         check_eq("stall.alu", bus.mem_alu_result, frozen_alu);
         check_eq("stall.wr",  bus.mem_write_reg, frozen_wr);
      end
      bus.flush = 1'b1;
      step("flushstall");
      check_eq("flushstall.valid", bus.mem_valid, 1'b0);
      bus.stall = 1'b0; bus.exc_clr = 1'b1;
      step("clr");
      check_eq("clr.pend", bus.exc_pending, 1'b0);
      bus.exc_clr = 1'b0; bus.ex_overflow = 1'b1; bus.ex_ovf_en = 1'b1;
      step("flushovf");
      check_eq("flushovf.req",  bus.exc_req, 1'b0);
      check_eq("flushovf.pend", bus.exc_pending, 1'b0);

      // Load instruction.
      idle_inputs();
      bus.ex_valid = 1'b1; bus.ex_mem_read = 1'b1; bus.ex_mem_to_reg = 1'b1;
      bus.ex_reg_write = 1'b1; bus.ex_write_reg = 5'd9;
      step("ld");
      check_eq("ld.ldp", bus.load_pending, 1'b1);
      check_eq("ld.fwd", bus.fwd_en, 1'b0);

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         rand_inputs();
         step("rnd");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
